// File: rtl/obi_mem_responder.sv
// Single-outstanding req/gnt/rvalid SRAM responder with configurable grant delay and response
// latency. Define OBI_MEM_RESPONDER_RANDOM_STALL_EN to add LFSR-driven extra grant stalls.
module obi_mem_responder #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
  parameter int unsigned GNT_DELAY      = 0,
  parameter int unsigned RVALID_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_error_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
  // Extra room for GNT_DELAY plus up to 3 random stall cycles.
  localparam int unsigned CntW = 5;
`else
  localparam int unsigned CntW = $clog2(16);
`endif
  localparam logic [CntW-1:0] LatLast = CntW'((RVALID_LATENCY > 1) ? RVALID_LATENCY - 2 : 0);

  if (RVALID_LATENCY == 0 || RVALID_LATENCY > 15 || GNT_DELAY > 15) begin : g_param_err
    $error("obi_mem_responder: GNT_DELAY must be 0..15 and RVALID_LATENCY 1..15");
  end

  typedef enum logic [1:0] {StIdle, StGntWait, StLatWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   new_dly, dly_q;
  logic              gnt;
  logic              addr_ok;
  logic [AW-1:0]     idx;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [MEM_WORDS];

`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign new_dly = CntW'(GNT_DELAY) + CntW'(lfsr_q[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
      dly_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (state_q == StIdle && mem_req_i) dly_q <= new_dly;
    end
  end
`else
  assign new_dly = CntW'(GNT_DELAY);
  assign dly_q   = new_dly;
`endif

  assign idx     = mem_addr_i[AW+1:2];
  assign addr_ok = (mem_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]) && (mem_addr_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req_i) begin
          if (new_dly == '0) begin
            gnt     = 1'b1;
            cnt_d   = '0;
            state_d = (RVALID_LATENCY == 1) ? StResp : StLatWait;
          end else begin
            // The first req cycle counts as cycle 0 of the grant delay.
            cnt_d   = CntW'(1);
            state_d = StGntWait;
          end
        end
      end
      StGntWait: begin
        if (!mem_req_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == dly_q) begin
          gnt     = 1'b1;
          cnt_d   = '0;
          state_d = (RVALID_LATENCY == 1) ? StResp : StLatWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLatWait: begin
        if (cnt_q == LatLast) begin
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_gnt_o = gnt & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (mem_gnt_o) begin
      err_q   <= ~addr_ok;
      rdata_q <= (addr_ok && !mem_we_i) ? mem_q[idx] : '0;
    end
  end

  // Array is deliberately not reset; gnt is already masked by reset.
  always_ff @(posedge clk) begin
    if (mem_gnt_o && addr_ok && mem_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_i[b]) mem_q[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  assign mem_rvalid_o = (state_q == StResp);
  assign mem_rdata_o  = mem_rvalid_o ? rdata_q : '0;
  assign mem_error_o  = mem_rvalid_o & err_q;

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- Memory-side responder (slave) for the req/gnt/rvalid bus driven by the set-associative cache's mem_* initiator port.
- Backs a word-addressed SRAM array and answers one transaction at a time.
- Grant delay and response latency are configurable.
- Used as the cache's backing store in simulation/FPGA bring-up and as a generic data-RAM slave on the core bus.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array (power of 2, >=4).
- BASE_ADDR, 32'h0010_0000, byte address of word 0; aligned to 4*MEM_WORDS.
- GNT_DELAY, 0, cycles from first sampled req to gnt (0..15).
- RVALID_LATENCY, 1, cycles from gnt cycle to rvalid cycle (1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req_i  input  1  request; held by initiator until gnt.
- mem_addr_i  input  32  byte address.
- mem_we_i  input  1  1=write, 0=read.
- mem_be_i  input  4  byte enables, bit n = byte n (bits 8n+7:8n).
- mem_wdata_i  input  32  write data.
- mem_gnt_o  output  1  single-cycle grant; request fields sampled in this cycle.
- mem_rvalid_o  output  1  single-cycle response valid; asserted for reads and writes.
- mem_rdata_o  output  32  read data, valid only with rvalid on a read.
- mem_error_o  output  1  error flag, valid only with rvalid.

Behaviour:
- Reset: synchronous, active-high. Next edge forces state IDLE and counters 0. mem_gnt_o=0 (gated while reset=1), mem_rvalid_o=0, mem_rdata_o=0, mem_error_o=0. Array contents are NOT cleared.
- FSM states:
  - IDLE: on req_i=1, go to GNT_WAIT, or grant immediately if GNT_DELAY=0 (gnt_o combinational from req_i, same cycle).
  - GNT_WAIT: counts GNT_DELAY cycles from first cycle req seen. gnt_o=1 in cycle GNT_DELAY, then go to LAT_WAIT.
  - LAT_WAIT: counts RVALID_LATENCY-1 cycles.
  - RESP: rvalid_o=1 for exactly one cycle, then IDLE.
  - Total: rvalid occurs exactly RVALID_LATENCY cycles after the gnt cycle.
- Capture: addr/we/be/wdata are taken at the gnt-cycle edge. Array write (byte-masked) and array read both occur at that edge, so a read granted after a write returns the new data.
- Request dropped during GNT_WAIT (protocol violation): return to IDLE, no gnt.
- One outstanding transaction; gnt_o=0 in LAT_WAIT and RESP. req_i held high through RESP is re-evaluated in IDLE, so the earliest next gnt is the cycle after rvalid (GNT_DELAY=0).
- Error: address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) or addr[1:0]!=0.
  - Transaction is still granted with normal timing.
  - No array access; rvalid with error_o=1, rdata_o=0.
- Write response: rdata_o=0, error_o=0 unless error.
- mem_rdata_o and mem_error_o return to 0 in every cycle without rvalid.
- be=4'b0000 write: granted and responded, array unchanged.
- Counters are $clog2(16) bits wide and saturate-free, since parameters are range-checked. An elaboration error is raised if RVALID_LATENCY=0 or either delay parameter >15.
- Reset mid-operation: pending transaction is dropped with no rvalid. A write whose gnt edge coincides with reset is not performed.

Optional Feature:
- Macro: OBI_MEM_RESPONDER_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advancing every cycle.
  - On leaving IDLE with a new request, lfsr[1:0] (0..3) is latched and added to GNT_DELAY for that transaction. With GNT_DELAY=0 and extra>0, gnt is no longer combinational and goes through GNT_WAIT.
  - Latency to rvalid is unchanged.
- Undefined: no LFSR; timing is fully deterministic per parameters.

Test Plan:
- Defaults, write 32'h1234_5678 be=4'hF to 32'h0010_0000 → gnt same cycle as req, rvalid next cycle, error=0. Then read same address → rvalid 1 cycle after gnt with rdata=32'h1234_5678.
- Byte mask: write 32'hAABB_CCDD be=4'b0101 over 32'h1234_5678 → subsequent read returns 32'h12BB_56DD.
- GNT_DELAY=2, RVALID_LATENCY=3: req rises cycle 0, held → gnt only in cycle 2, rvalid only in cycle 5, all other cycles gnt=rvalid=0.
- Line-fill pattern: four sequential reads 0x00100010..0x0010001C (preloaded 1,2,3,4), req held continuously → four gnt/rvalid pairs, rdata 1,2,3,4 in order, each gnt ≥1 cycle after previous rvalid.
- Errors: read 32'h0010_1000 (MEM_WORDS=1024) → rvalid, error=1, rdata=0. Write to 32'h0010_0002 → error=1 and word 0 unchanged on readback.
- Reset asserted for 1 cycle in LAT_WAIT of a read → no rvalid ever for it; all outputs 0 next cycle; earlier-written word still reads back correctly.
